mio_responder: RTL and testbench
================================

# mio_responder

Memory/IO responder for `multi_cycle_cpu`: it is the slave end of the CPU's `mio_ready` handshake. It decodes each CPU access to a word-addressed data RAM, a timer/interrupt register bank, or unmapped space, and answers with read data and a one-cycle `mio_ready` pulse. It also drives the CPU's `INTsignal` from the timer.

## Interface
- `RAM_AW`, 10: RAM word-address width (RAM depth is 2^RAM_AW words).
- `RAM_LAT`, 2: RAM access latency in cycles, ≥1.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: access request, level; held by the CPU until `mio_ready`.
- `cpu_we` in 1: 1 = write, 0 = read; qualified by `cpu_req`.
- `cpu_addr` in 32: byte address; bits [1:0] ignored.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: read data; valid only while `mio_ready`=1.
- `mio_ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: one-cycle pulse coincident with `mio_ready` for an unmapped access.
- `INTsignal` out 1: level interrupt, `pending & int_en`.

## Operation
- Address map:
  - `addr[31:28]=0x0`: RAM at word `addr[RAM_AW+1:2]`, upper bits aliased.
  - `0xF000_0000` LOAD (RW).
  - `0xF000_0004` CTRL (RW; bit0 `en`, bit1 `int_en`, bit2 `auto`; other bits read 0).
  - `0xF000_0008` COUNT (RO).
  - `0xF000_000C` STATUS (bit0 `pending`; write 1 clears, write 0 no effect).
  - Anything else is unmapped: reads return 0, writes are ignored, `bus_err` pulses.
- FSM states:
  - IDLE: samples `cpu_req`. On a request it latches addr/we/wdata.
    - RAM access: go to WAIT with `cnt = RAM_LAT-1`, or straight to RESP if `RAM_LAT=1`.
    - Register or unmapped access: go to RESP.
  - WAIT: decrement `cnt`; go to RESP when `cnt` reaches 1.
  - RESP: `mio_ready=1`, `cpu_rdata` driven; next state is IDLE unconditionally.
- Register write commits at the edge leaving IDLE. RAM write commits at the edge entering RESP.
- A request still high in the IDLE cycle after RESP is a new access. The back-to-back minimum is 1 idle cycle between `mio_ready` pulses.
- `cpu_req` changes while in WAIT/RESP are ignored; the latched values are used.
- Timer (runs every cycle, independent of FSM):
  - If `en` and COUNT≠0: COUNT−1.
  - If `en` and COUNT=0: set `pending`. Then if `auto`, COUNT←LOAD; otherwise `en`←0.
  - Writing LOAD also sets COUNT←LOAD that cycle; this has priority over the decrement.
  - The same cycle's expiry set beats a STATUS write-1 clear, so `pending` stays 1.
  - A CTRL write in the expiry cycle overrides the `en`←0 auto-clear.
- Reset values:
  - Outputs: `mio_ready`=0, `bus_err`=0, `cpu_rdata`=0, `INTsignal`=0.
  - State: FSM=IDLE; LOAD, COUNT, CTRL and `pending` all 0.
  - RAM contents are not reset.
- Reset mid-access: the FSM returns to IDLE, no `mio_ready` is issued, and an uncommitted RAM write is dropped.

## Timing
- Request sampled at edge 0 (cycle 0). `mio_ready` is high in cycle 1 for register/unmapped accesses and in cycle `RAM_LAT` for RAM.
- `cpu_rdata` and `bus_err` are registered and valid only during the `mio_ready` cycle; `cpu_rdata` is 0 otherwise.
- A register read returns the value before any same-cycle timer update. COUNT read is the value at edge 0.
- `INTsignal` is registered. It rises 1 cycle after the edge where `pending` sets (with `int_en`=1). It falls 1 cycle after the clearing write or after `int_en`←0.

## Test plan
- RAM write then read, `RAM_LAT`=2: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → `mio_ready` in cycle 2 of each access, `cpu_rdata`=0xDEADBEEF; alias 0x0000_1010 (`RAM_AW`=10) also returns 0xDEADBEEF.
- Register latency: write LOAD=5, read LOAD → `mio_ready` in cycle 1, `cpu_rdata`=5; read COUNT immediately → 5.
- Timer one-shot: LOAD=3, CTRL=0x3 → `pending`=1 after COUNT reaches 0; `INTsignal`=1; CTRL reads 0x2 (`en` cleared); STATUS write 1 → `INTsignal`=0 one cycle later.
- Auto-reload with simultaneous clear: LOAD=2, CTRL=0x7; issue STATUS write-1 on an expiry cycle → `pending` remains 1; COUNT reloads to 2 and periodic expiry continues every 3 cycles.
- Unmapped access: read 0x8000_0000 → `mio_ready` and `bus_err` both high in cycle 1, `cpu_rdata`=0; write there → no state change.
- Reset mid-RAM-write (`RAM_LAT`=4, reset asserted in cycle 2) → no `mio_ready`; later read of that address returns the old value; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/mio_responder.sv
// Memory/IO slave for multi_cycle_cpu: word RAM, timer/interrupt registers and
// an unmapped-space error path, answered with a one-cycle mio_ready pulse.
module mio_responder #(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        mio_ready,
    output logic        bus_err,
    output logic        INTsignal
);

    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [RAM_AW-1:0] ridx_q;
    logic              we_q;
    logic [31:0]       wdata_q;

    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;
    logic        int_q;

    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        en_q, en_d;
    logic        int_en_q, int_en_d;
    logic        auto_q, auto_d;
    logic        pend_q, pend_d;

    logic [31:0] mem [2**RAM_AW];

    // Decode of the live CPU request, only meaningful in IDLE
    logic        is_ram;
    logic        is_reg;
    logic [1:0]  reg_sel;
    logic        acc;
    logic        reg_wr;
    logic        wr_load;
    logic        wr_ctrl;
    logic        wr_stat;
    logic [31:0] reg_rdata;
    logic        unused_addr;

    assign is_ram      = (cpu_addr[31:28] == 4'h0);
    assign is_reg      = (cpu_addr[31:4] == 28'hF00_0000);
    assign reg_sel     = cpu_addr[3:2];
    assign acc         = (state_q == IDLE) && cpu_req;
    assign reg_wr      = acc && is_reg && cpu_we;
    assign wr_load     = reg_wr && (reg_sel == 2'd0);
    assign wr_ctrl     = reg_wr && (reg_sel == 2'd1);
    assign wr_stat     = reg_wr && (reg_sel == 2'd3);
    assign unused_addr = ^cpu_addr[1:0];

    always_comb begin
        reg_rdata = '0;
        unique case (reg_sel)
            2'd0: reg_rdata = load_q;
            2'd1: reg_rdata = {29'd0, auto_q, int_en_q, en_q};
            2'd2: reg_rdata = count_q;
            2'd3: reg_rdata = {31'd0, pend_q};
        endcase
    end

    // RAM port: driven from the live request when latency is 1, else latched
    logic              ram_go;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic [31:0]       ram_wd;
    logic [31:0]       ram_rd;

    assign ram_go  = (acc && is_ram && (RAM_LAT == 1))
                  || ((state_q == WAIT) && (cnt_q == CW'(1)));
    assign ram_idx = (state_q == IDLE) ? cpu_addr[RAM_AW+1:2] : ridx_q;
    assign ram_we  = (state_q == IDLE) ? cpu_we : we_q;
    assign ram_wd  = (state_q == IDLE) ? cpu_wdata : wdata_q;
    assign ram_rd  = mem[ram_idx];

    always_ff @(posedge clk) begin
        if (!reset && ram_go && ram_we) begin
            mem[ram_idx] <= ram_wd;
        end
    end

    // Timer: CPU writes take priority over the free-running update
    logic expire;

    always_comb begin
        expire   = en_q && (count_q == '0);
        load_d   = load_q;
        count_d  = count_q;
        en_d     = en_q;
        int_en_d = int_en_q;
        auto_d   = auto_q;
        pend_d   = pend_q;
        if (en_q && (count_q != '0)) begin
            count_d = count_q - 32'd1;
        end else if (expire && auto_q) begin
            count_d = load_q;
        end
        if (expire && !auto_q) begin
            en_d = 1'b0;
        end
        if (wr_load) begin
            load_d  = cpu_wdata;
            count_d = cpu_wdata;
        end
        if (wr_ctrl) begin
            {auto_d, int_en_d, en_d} = cpu_wdata[2:0];
        end
        if (wr_stat && cpu_wdata[0]) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ridx_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            int_q    <= 1'b0;
            load_q   <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            int_en_q <= 1'b0;
            auto_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            load_q   <= load_d;
            count_q  <= count_d;
            en_q     <= en_d;
            int_en_q <= int_en_d;
            auto_q   <= auto_d;
            pend_q   <= pend_d;
            int_q    <= pend_q & int_en_q;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        ridx_q  <= cpu_addr[RAM_AW+1:2];
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        if (is_ram) begin
                            if (RAM_LAT == 1) begin
                                state_q <= RESP;
                                ready_q <= 1'b1;
                                rdata_q <= cpu_we ? '0 : ram_rd;
                            end else begin
                                state_q <= WAIT;
                                cnt_q   <= CW'(RAM_LAT - 1);
                            end
                        end else begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= !is_reg;
                            rdata_q <= (is_reg && !cpu_we) ? reg_rdata : '0;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= we_q ? '0 : ram_rd;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign mio_ready = ready_q;
    assign bus_err   = err_q;
    assign INTsignal = int_q;

endmodule

// File: tb/tb_mio_responder.sv
// Bench for mio_responder: directed scenarios plus randomized accesses
// checked against a cycle-level reference model of the map and timer.
module tb_mio_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mio_ready;
    logic        bus_err;
    logic        INTsignal;

    always #5 clk = ~clk;

    mio_responder #(.RAM_AW(AW), .RAM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mio_ready (mio_ready),
        .bus_err   (bus_err),
        .INTsignal (INTsignal)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [31:0] m_mem [int];
    logic [31:0] m_load, m_count;
    bit          m_en, m_ien, m_auto, m_pend, m_int;

    task automatic m_reset();
        m_load  = 0;
        m_count = 0;
        m_en    = 0;
        m_ien   = 0;
        m_auto  = 0;
        m_pend  = 0;
        m_int   = 0;
    endtask

    task automatic tick(bit wl, bit wc, bit ws, logic [31:0] wd);
        bit          ex;
        bit          nint;
        bit          nen;
        logic [31:0] nc;
        @(posedge clk);
        if (reset) begin
            m_reset();
        end else begin
            ex   = m_en && (m_count == 0);
            nint = m_pend && m_ien;
            nc   = m_count;
            nen  = m_en;
            if (m_en && m_count != 0) nc = m_count - 1;
            if (ex && m_auto) nc = m_load;
            if (ex && !m_auto) nen = 0;
            if (wl) begin
                m_load = wd;
                nc     = wd;
            end
            if (wc) begin
                nen    = wd[0];
                m_ien  = wd[1];
                m_auto = wd[2];
            end
            if (ws && wd[0]) m_pend = 0;
            if (ex) m_pend = 1;
            m_count = nc;
            m_en    = nen;
            m_int   = nint;
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 0, 0);
            chk("int_idle", 32'(INTsignal), 32'(m_int));
            chk("rdata_idle", cpu_rdata, 32'h0);
        end
    endtask

    task automatic access(string tag, bit we, logic [31:0] a,
                          logic [31:0] wd, output logic [31:0] rd);
        bit          ram, rg, known;
        logic [1:0]  sel;
        logic [31:0] expd;
        int          lat, n, key;
        ram   = (a[31:28] == 4'h0);
        rg    = (a[31:4] == 28'hF00_0000);
        sel   = a[3:2];
        key   = int'(a[AW+1:2]);
        known = 1;
        expd  = 0;
        lat   = 1;
        if (ram) begin
            lat = LAT;
            if (we) m_mem[key] = wd;
            else if (m_mem.exists(key)) expd = m_mem[key];
            else known = 0;
        end else if (rg && !we) begin
            case (sel)
                2'd0: expd = m_load;
                2'd1: expd = {29'd0, m_auto, m_ien, m_en};
                2'd2: expd = m_count;
                default: expd = {31'd0, m_pend};
            endcase
        end
        @(negedge clk);
        cpu_req   = 1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        tick(rg && we && sel == 2'd0, rg && we && sel == 2'd1,
             rg && we && sel == 2'd3, wd);
        n = 1;
        while (!mio_ready && n < 16) begin
            tick(0, 0, 0, 0);
            n++;
        end
        rd = cpu_rdata;
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_err"}, 32'(bus_err), 32'(!ram && !rg));
        if (!we && known) chk({tag, "_data"}, cpu_rdata, expd);
        @(negedge clk);
        cpu_req = 0;
        tick(0, 0, 0, 0);
        chk({tag, "_rdy_off"}, 32'(mio_ready), 32'h0);
    endtask

    logic [31:0] rd;
    logic [31:0] a;
    int          k, sel, idx;

    initial begin
        reset     = 1;
        cpu_req   = 0;
        cpu_we    = 0;
        cpu_addr  = 0;
        cpu_wdata = 0;
        m_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        @(negedge clk);
        reset = 0;
        chk("rst_ready", 32'(mio_ready), 32'h0);
        chk("rst_err", 32'(bus_err), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_int", 32'(INTsignal), 32'h0);

        // RAM write, read back, and aliased read
        access("ram_wr", 1, 32'h0000_0010, 32'hDEAD_BEEF, rd);
        access("ram_rd", 0, 32'h0000_0010, 0, rd);
        chk("ram_rd_const", rd, 32'hDEAD_BEEF);
        access("ram_alias", 0, 32'h0000_1010, 0, rd);
        chk("ram_alias_const", rd, 32'hDEAD_BEEF);

        // Register latency
        access("load_wr", 1, 32'hF000_0000, 5, rd);
        access("load_rd", 0, 32'hF000_0000, 0, rd);
        chk("load_const", rd, 32'd5);
        access("count_rd", 0, 32'hF000_0008, 0, rd);
        chk("count_const", rd, 32'd5);

        // One-shot timer
        access("os_load", 1, 32'hF000_0000, 3, rd);
        access("os_ctrl", 1, 32'hF000_0004, 3, rd);
        idle(8);
        chk("os_int_hi", 32'(INTsignal), 32'h1);
        access("os_ctrl_rd", 0, 32'hF000_0004, 0, rd);
        chk("os_ctrl_const", rd, 32'h2);
        access("os_clr", 1, 32'hF000_000C, 1, rd);
        idle(1);
        chk("os_int_lo", 32'(INTsignal), 32'h0);

        // Auto-reload with a clear on the expiry edge
        access("ar_load", 1, 32'hF000_0000, 2, rd);
        access("ar_ctrl", 1, 32'hF000_0004, 7, rd);
        k = 0;
        while (!(m_en && m_count == 0) && k < 10) begin
            idle(1);
            k++;
        end
        access("ar_clr", 1, 32'hF000_000C, 1, rd);
        access("ar_stat", 0, 32'hF000_000C, 0, rd);
        chk("ar_pend_const", rd, 32'h1);
        access("ar_count", 0, 32'hF000_0008, 0, rd);
        idle(4);
        access("ar_count2", 0, 32'hF000_0008, 0, rd);
        access("ar_off", 1, 32'hF000_0004, 0, rd);
        access("ar_clr2", 1, 32'hF000_000C, 1, rd);
        idle(2);

        // Unmapped access
        access("um_rd", 0, 32'h8000_0000, 0, rd);
        chk("um_rd_const", rd, 32'h0);
        access("um_wr", 1, 32'h8000_0000, 32'h1234_5678, rd);
        access("um_load", 0, 32'hF000_0000, 0, rd);
        access("um_ctrl", 0, 32'hF000_0004, 0, rd);

        // Reset in the middle of a RAM write
        access("mr_old", 1, 32'h0000_0040, 32'h1111_1111, rd);
        @(negedge clk);
        cpu_req   = 1;
        cpu_we    = 1;
        cpu_addr  = 32'h0000_0040;
        cpu_wdata = 32'h2222_2222;
        tick(0, 0, 0, 0);
        chk("mr_no_rdy0", 32'(mio_ready), 32'h0);
        @(negedge clk);
        reset = 1;
        tick(0, 0, 0, 0);
        chk("mr_no_rdy1", 32'(mio_ready), 32'h0);
        chk("mr_err", 32'(bus_err), 32'h0);
        chk("mr_rdata", cpu_rdata, 32'h0);
        chk("mr_int", 32'(INTsignal), 32'h0);
        @(negedge clk);
        reset   = 0;
        cpu_req = 0;
        idle(1);
        access("mr_rd", 0, 32'h0000_0040, 0, rd);
        chk("mr_old_const", rd, 32'h1111_1111);

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5) begin
                idx = $urandom_range(0, 15);
                a = {4'h0, 16'($urandom), 10'(idx), 2'($urandom)};
                access("rnd_ram", 1'($urandom), a, $urandom, rd);
            end else if (k < 9) begin
                sel = $urandom_range(0, 3);
                a = {28'hF00_0000, 2'(sel), 2'($urandom)};
                if (sel == 0)
                    access("rnd_reg", 1'($urandom), a,
                           32'($urandom_range(0, 6)), rd);
                else
                    access("rnd_reg", 1'($urandom), a, $urandom, rd);
            end else begin
                a = {4'($urandom_range(1, 14)), 28'($urandom)};
                access("rnd_um", 1'($urandom), a, $urandom, rd);
            end
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
